// File: rtl/multicycle_arith_machine_pkg.sv
// Shared constants for the multicycle arithmetic machine: instruction encodings,
// ALU operation codes and the controller state enum.
package multicycle_arith_machine_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_e;

endpackage

// File: rtl/multicycle_arith_machine_if.sv
// Instruction-memory port: the machine (master) requests, memory (slave) answers.
interface multicycle_arith_machine_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_valid;
  logic [31:0]      imem_data;

  modport master (output imem_req, imem_addr, input imem_valid, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_valid, imem_data);
endinterface

// File: rtl/multicycle_arith_machine_decode.sv
// Combinational instruction decoder: ALU op, destination select, immediate handling
// and illegal-instruction detection (unknown encodings or out-of-range registers).
module mc_decode
  import multicycle_arith_machine_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic [31:0] instr_i,
  output alu_op_e     alu_op_o,
  output logic        use_imm_o,
  output logic        imm_sign_o,
  output logic        dest_rt_o,
  output logic        illegal_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [15:0] imm_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       badOp;
  logic       badReg;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];
  assign rs_o   = instr_i[25:21];
  assign rt_o   = instr_i[20:16];
  assign rd_o   = instr_i[15:11];
  assign imm_o  = instr_i[15:0];

  always_comb begin
    alu_op_o   = ALU_ADD;
    use_imm_o  = 1'b1;
    imm_sign_o = 1'b0;
    dest_rt_o  = 1'b1;
    badOp      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        use_imm_o = 1'b0;
        dest_rt_o = 1'b0;
        case (funct)
          FN_ADD:  alu_op_o = ALU_ADD;
          FN_SUB:  alu_op_o = ALU_SUB;
          FN_AND:  alu_op_o = ALU_AND;
          FN_OR:   alu_op_o = ALU_OR;
          FN_XOR:  alu_op_o = ALU_XOR;
          FN_NOR:  alu_op_o = ALU_NOR;
          default: badOp = 1'b1;
        endcase
      end
      OP_ADDI: begin
        alu_op_o   = ALU_ADD;
        imm_sign_o = 1'b1;
      end
      OP_ANDI: alu_op_o = ALU_AND;
      OP_ORI:  alu_op_o = ALU_OR;
      OP_XORI: alu_op_o = ALU_XOR;
      default: badOp = 1'b1;
    endcase
    // The rd field only names a register for R-type; in I-type it is immediate bits.
    badReg = (32'(rs_o) >= NREGS) || (32'(rt_o) >= NREGS) ||
             (!dest_rt_o && (32'(rd_o) >= NREGS));
  end

  assign illegal_o = badOp | badReg;

endmodule

// File: rtl/multicycle_arith_machine.sv
// Multicycle FETCH/DECODE/EXECUTE/WRITEBACK machine with register file and ALU;
// halts with a sticky exception flag on an illegal instruction.
module multicycle_arith_machine
  import multicycle_arith_machine_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  multicycle_arith_machine_if.master  imem,
  output logic                        except,
  output logic [31:0]                 retired
);

  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] result_q;
  logic [31:0]      ir_q;
  logic [31:0]      retired_q;
  logic             req_q;
  logic             except_q;
  logic [WIDTH-1:0] rf_q [NREGS];

  alu_op_e          aluOp;
  logic             useImm;
  logic             immSign;
  logic             destRt;
  logic             illegal;
  logic [4:0]       rsField;
  logic [4:0]       rtField;
  logic [4:0]       rdField;
  logic [15:0]      imm;
  logic [WIDTH-1:0] imm_ext_d;
  logic [WIDTH-1:0] alu_d;
  logic [RW-1:0]    rsIdx;
  logic [RW-1:0]    rtIdx;
  logic [RW-1:0]    dstIdx;

  mc_decode #(.NREGS(NREGS)) u_decode (
    .instr_i    (ir_q),
    .alu_op_o   (aluOp),
    .use_imm_o  (useImm),
    .imm_sign_o (immSign),
    .dest_rt_o  (destRt),
    .illegal_o  (illegal),
    .rs_o       (rsField),
    .rt_o       (rtField),
    .rd_o       (rdField),
    .imm_o      (imm)
  );

  assign rsIdx  = rsField[RW-1:0];
  assign rtIdx  = rtField[RW-1:0];
  assign dstIdx = destRt ? rtField[RW-1:0] : rdField[RW-1:0];

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign except         = except_q;
  assign retired        = retired_q;

  always_comb begin
    imm_ext_d = WIDTH'(imm);
    if (immSign && imm[15]) imm_ext_d = imm_ext_d | ~WIDTH'(16'hFFFF);
  end

  always_comb begin
    case (aluOp)
      ALU_ADD: alu_d = opa_q + opb_q;
      ALU_SUB: alu_d = opa_q - opb_q;
      ALU_AND: alu_d = opa_q & opb_q;
      ALU_OR:  alu_d = opa_q | opb_q;
      ALU_XOR: alu_d = opa_q ^ opb_q;
      ALU_NOR: alu_d = ~(opa_q | opb_q);
      default: alu_d = '0;
    endcase
  end

  // The instruction register stays stable from DECODE through WRITEBACK, so the
  // decoder outputs remain valid for the ALU op and destination in later states.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      req_q     <= 1'b1;
      except_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem.imem_valid) begin
            ir_q    <= imem.imem_data;
            req_q   <= 1'b0;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (illegal) begin
            except_q <= 1'b1;
            state_q  <= ST_HALT;
          end else begin
            opa_q   <= rf_q[rsIdx];
            opb_q   <= useImm ? imm_ext_d : rf_q[rtIdx];
            state_q <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          result_q <= alu_d;
          state_q  <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          if (dstIdx != '0) rf_q[dstIdx] <= result_q;
          pc_q      <= pc_q + WIDTH'(4);
          retired_q <= retired_q + 32'd1;
          req_q     <= 1'b1;
          state_q   <= ST_FETCH;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_arith_machine.sv
// Self-checking bench: directed phases plus random legal programs compared against
// an instruction-level reference model of the architectural state.
module tb_multicycle_arith_machine;

  logic        clock = 1'b0;
  logic        reset;
  logic        resetB;
  logic        validA;
  logic        validB;
  logic        exceptA, exceptB;
  logic [31:0] retiredA, retiredB;
  logic [31:0] progA [256];
  logic [31:0] progB [256];

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mRegs [32];
  logic [31:0] mPc;
  logic [31:0] mRet;
  logic        mHalt;

  always #5 clock = ~clock;

  multicycle_arith_machine_if #(.WIDTH(32)) ifA ();
  multicycle_arith_machine_if #(.WIDTH(32)) ifB ();

  assign ifA.imem_valid = validA;
  assign ifA.imem_data  = progA[ifA.imem_addr[9:2]];
  assign ifB.imem_valid = validB;
  assign ifB.imem_data  = progB[ifB.imem_addr[9:2]];

  multicycle_arith_machine #(.WIDTH(32), .NREGS(32)) dutA (
    .clock   (clock),
    .reset   (reset),
    .imem    (ifA),
    .except  (exceptA),
    .retired (retiredA)
  );

  multicycle_arith_machine #(.WIDTH(32), .NREGS(8)) dutB (
    .clock   (clock),
    .reset   (resetB),
    .imem    (ifB),
    .except  (exceptB),
    .retired (retiredB)
  );

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    rtype = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] im);
    itype = {op, 5'(rs), 5'(rt), im};
  endfunction

  function automatic logic [31:0] randLegal();
    int k = $urandom_range(0, 9);
    int rs = $urandom_range(0, 31);
    int rt = $urandom_range(0, 31);
    int rd = $urandom_range(0, 31);
    logic [15:0] im = 16'($urandom);
    case (k)
      0: randLegal = rtype(rs, rt, rd, 6'h20);
      1: randLegal = rtype(rs, rt, rd, 6'h22);
      2: randLegal = rtype(rs, rt, rd, 6'h24);
      3: randLegal = rtype(rs, rt, rd, 6'h25);
      4: randLegal = rtype(rs, rt, rd, 6'h26);
      5: randLegal = rtype(rs, rt, rd, 6'h27);
      6: randLegal = itype(6'h08, rs, rt, im);
      7: randLegal = itype(6'h0C, rs, rt, im);
      8: randLegal = itype(6'h0D, rs, rt, im);
      default: randLegal = itype(6'h0E, rs, rt, im);
    endcase
  endfunction

  task automatic modelReset();
    for (int r = 0; r < 32; r++) mRegs[r] = '0;
    mPc   = '0;
    mRet  = '0;
    mHalt = 1'b0;
  endtask

  // One whole instruction at the architectural level: result lands in rd/rt, PC and count advance.
  task automatic modelExec(input logic [31:0] ins);
    logic [5:0]  op   = ins[31:26];
    logic [5:0]  fn   = ins[5:0];
    logic [31:0] a    = mRegs[ins[25:21]];
    logic [31:0] b    = mRegs[ins[20:16]];
    logic [31:0] uimm = {16'h0000, ins[15:0]};
    logic [31:0] simm = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] v    = '0;
    int          dst;
    bit          ok   = 1'b1;
    if (op == 6'h00) begin
      dst = int'(ins[15:11]);
      case (fn)
        6'h20: v = a + b;
        6'h22: v = a - b;
        6'h24: v = a & b;
        6'h25: v = a | b;
        6'h26: v = a ^ b;
        6'h27: v = ~(a | b);
        default: ok = 1'b0;
      endcase
    end else begin
      dst = int'(ins[20:16]);
      case (op)
        6'h08: v = a + simm;
        6'h0C: v = a & uimm;
        6'h0D: v = a | uimm;
        6'h0E: v = a ^ uimm;
        default: ok = 1'b0;
      endcase
    end
    if (!ok) mHalt = 1'b1;
    else begin
      if (dst != 0) mRegs[dst] = v;
      mPc  = mPc + 32'd4;
      mRet = mRet + 32'd1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag);
    for (int r = 0; r < 32; r++)
      checkOutput($sformatf("%s r%0d", tag, r), 64'(dutA.rf_q[r]), 64'(mRegs[r]));
    checkOutput({tag, " pc"}, 64'(ifA.imem_addr), 64'(mPc));
    checkOutput({tag, " retired"}, 64'(retiredA), 64'(mRet));
    checkOutput({tag, " except"}, 64'(exceptA), 64'(mHalt));
  endtask

  // Called at the negedge of the first FETCH cycle; stalls imem_valid for 'stall' cycles.
  task automatic applyStimulus(input int stall, input string tag);
    logic [31:0] ins = progA[mPc[9:2]];
    if (stall > 0) validA = 1'b0;
    for (int s = 0; s < stall; s++) begin
      checkOutput({tag, " stall req"}, 64'(ifA.imem_req), 64'd1);
      checkOutput({tag, " stall addr"}, 64'(ifA.imem_addr), 64'(mPc));
      @(negedge clock);
    end
    validA = 1'b1;
    @(negedge clock);
    checkOutput({tag, " decode req"}, 64'(ifA.imem_req), 64'd0);
    repeat (2) @(negedge clock);
    checkOutput({tag, " early retire"}, 64'(retiredA), 64'(mRet));
    @(negedge clock);
    modelExec(ins);
    checkState(tag);
  endtask

  initial begin
    reset  = 1'b0;
    resetB = 1'b0;
    validA = 1'b1;
    validB = 1'b1;
    for (int i = 0; i < 256; i++) begin
      progA[i] = randLegal();
      progB[i] = '0;
    end
    progA[0] = itype(6'h08, 0, 1, 16'hFFFF);
    progA[1] = itype(6'h08, 0, 2, 16'd5);
    progA[2] = rtype(1, 2, 3, 6'h20);
    progA[3] = itype(6'h0D, 0, 4, 16'h8000);
    progA[4] = itype(6'h0C, 4, 5, 16'hFFFF);
    progA[5] = itype(6'h08, 0, 6, 16'h8000);
    modelReset();

    // Reset state and the first program
    repeat (2) @(negedge clock);
    checkState("reset");
    reset = 1'b1;
    checkOutput("release req", 64'(ifA.imem_req), 64'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("fetch addr %0d", i), 64'(ifA.imem_addr), 64'(4 * i));
      applyStimulus(0, $sformatf("p1 i%0d", i));
    end
    checkOutput("r3 add", 64'(dutA.rf_q[3]), 64'd4);
    checkOutput("retired at 12", 64'(retiredA), 64'd3);
    checkOutput("fetch addr 3", 64'(ifA.imem_addr), 64'd12);
    for (int i = 3; i < 6; i++) applyStimulus(0, $sformatf("p1 i%0d", i));
    checkOutput("ori zext", 64'(dutA.rf_q[4]), 64'h0000_8000);
    checkOutput("andi zext", 64'(dutA.rf_q[5]), 64'h0000_8000);
    checkOutput("addi sext", 64'(dutA.rf_q[6]), 64'hFFFF_8000);
    for (int i = 6; i < 46; i++) applyStimulus($urandom_range(0, 2), $sformatf("rand i%0d", i));

    // Stalled second fetch, then an illegal opcode at PC 8
    reset = 1'b0;
    progA[0] = randLegal();
    progA[1] = randLegal();
    progA[2] = itype(6'h23, 1, 2, 16'h0010);
    #1;
    modelReset();
    checkState("async reset");
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(0, "p2 i0");
    applyStimulus(5, "p2 stall");
    @(negedge clock);
    checkOutput("illegal decode except", 64'(exceptA), 64'd0);
    @(negedge clock);
    modelExec(progA[2]);
    checkOutput("illegal except", 64'(exceptA), 64'd1);
    for (int c = 0; c < 20; c++) begin
      checkState($sformatf("halt c%0d", c));
      checkOutput("halt req", 64'(ifA.imem_req), 64'd0);
      @(negedge clock);
    end

    // Reset during EXECUTE of sub $1,$1,$1
    progA[0] = itype(6'h08, 0, 1, 16'd9);
    progA[1] = rtype(1, 1, 1, 6'h22);
    reset = 1'b0;
    #1;
    checkOutput("halt cleared", 64'(exceptA), 64'd0);
    modelReset();
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(0, "p3 i0");
    checkOutput("r1 nine", 64'(dutA.rf_q[1]), 64'd9);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("mid except", 64'(exceptA), 64'd0);
    checkOutput("mid r1", 64'(dutA.rf_q[1]), 64'd0);
    checkOutput("mid pc", 64'(ifA.imem_addr), 64'd0);
    checkOutput("mid retired", 64'(retiredA), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    checkOutput("post req", 64'(ifA.imem_req), 64'd1);
    checkOutput("post addr", 64'(ifA.imem_addr), 64'd0);

    // Eight-register machine: out-of-range rd is illegal
    progB[0] = itype(6'h08, 0, 1, 16'd3);
    progB[1] = rtype(1, 2, 9, 6'h20);
    resetB = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("B r1", 64'(dutB.rf_q[1]), 64'd3);
    repeat (2) @(negedge clock);
    checkOutput("B except", 64'(exceptB), 64'd1);
    repeat (5) @(negedge clock);
    checkOutput("B halt retired", 64'(retiredB), 64'd1);
    checkOutput("B halt pc", 64'(ifB.imem_addr), 64'd4);
    checkOutput("B halt r1", 64'(dutB.rf_q[1]), 64'd3);

    // Writes to register 0 are dropped but still retire
    resetB = 1'b0;
    progB[0] = itype(6'h08, 0, 0, 16'd7);
    @(negedge clock);
    resetB = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("B r0", 64'(dutB.rf_q[0]), 64'd0);
    checkOutput("B r0 retired", 64'(retiredB), 64'd1);
    checkOutput("B r0 except", 64'(exceptB), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
